// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
//
// Control FSM placed directly in front of a free-running 3-bit up/down counter.
// The counter has no enable and steps every cycle, so this block steers it
// with up_down and holds it at 0 through cnt_rst whenever no sweep is active.
// On an accepted start it makes the counter run a triangle wave between the
// captured bounds lo and hi for n_sweeps complete lo->hi->lo sweeps.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   request pulse, only looked at in IDLE
//   lo, hi     in   [2:0] sweep bounds, captured on an accepted start
//   n_sweeps   in   [SWEEPS_W-1:0] sweeps requested, captured on accepted start
//   cnt_in     in   [2:0] current counter value (counter out)
//   up_down    out  counter direction, 1 = up (combinational)
//   cnt_rst    out  counter reset (combinational, includes reset)
//   busy       out  high while a sweep run is in progress
//   done       out  one-cycle pulse after the last sweep completes
//   err        out  registered one-cycle pulse on a rejected start
//   sweep_cnt  out  [SWEEPS_W-1:0] sweeps completed in the current/last run
// -----------------------------------------------------------------------------
module updown_sweep_ctrl #(
    parameter int SWEEPS_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          lo,
    input  logic [2:0]          hi,
    input  logic [SWEEPS_W-1:0] n_sweeps,
    input  logic [2:0]          cnt_in,
    output logic                up_down,
    output logic                cnt_rst,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SWEEPS_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_UP    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [2:0]          lo_r;
    logic [2:0]          hi_r;
    logic [SWEEPS_W-1:0] n_r;
    logic [SWEEPS_W-1:0] sweep_cnt_r;
    logic                err_r;

    logic                params_ok_s;
    logic                start_ok_s;
    logic                start_bad_s;
    logic                at_lo_s;
    logic                at_hi_s;
    logic [SWEEPS_W-1:0] turn_cnt_s;
    logic                final_turn_s;
    logic                cnt_rst_state_s;

    // A request is only legal with a non-empty range and at least one sweep.
    assign params_ok_s  = (lo < hi) && (n_sweeps != {SWEEPS_W{1'b0}});
    assign start_ok_s   = (state_r == ST_IDLE) && start && params_ok_s;
    assign start_bad_s  = (state_r == ST_IDLE) && start && !params_ok_s;

    assign at_lo_s      = (cnt_in == lo_r);
    assign at_hi_s      = (cnt_in == hi_r);

    // Sweep count as it will be after the turn at lo; it never exceeds n_r
    // because a turn that reaches n_r ends the run.
    assign turn_cnt_s   = sweep_cnt_r + {{(SWEEPS_W-1){1'b0}}, 1'b1};
    assign final_turn_s = (state_r == ST_DOWN) && at_lo_s && (turn_cnt_s == n_r);

    // Reset forces the counter to 0 in the same cycle, before the FSM reacts.
    assign cnt_rst      = reset | cnt_rst_state_s;
    assign sweep_cnt    = sweep_cnt_r;
    assign err          = err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; turn decisions use the live cnt_in so no overshoot.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    next_state_s = ST_PRIME;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PRIME: begin
                if (at_lo_s) begin
                    next_state_s = ST_UP;
                end else begin
                    next_state_s = ST_PRIME;
                end
            end
            ST_UP: begin
                if (at_hi_s) begin
                    next_state_s = ST_DOWN;
                end else begin
                    next_state_s = ST_UP;
                end
            end
            ST_DOWN: begin
                if (at_lo_s) begin
                    if (final_turn_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_UP;
                    end
                end else begin
                    next_state_s = ST_DOWN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode; defaults describe the safe idle condition (counter held).
    always_comb begin
        up_down         = 1'b1;
        cnt_rst_state_s = 1'b1;
        busy            = 1'b0;
        done            = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_rst_state_s = 1'b1;
            end
            ST_PRIME: begin
                busy            = 1'b1;
                cnt_rst_state_s = 1'b0;
            end
            ST_UP: begin
                busy            = 1'b1;
                cnt_rst_state_s = 1'b0;
                if (at_hi_s) begin
                    up_down = 1'b0;
                end else begin
                    up_down = 1'b1;
                end
            end
            ST_DOWN: begin
                busy = 1'b1;
                if (at_lo_s) begin
                    // Turn back up, or on the last sweep park the counter at 0.
                    up_down         = 1'b1;
                    cnt_rst_state_s = final_turn_s;
                end else begin
                    up_down         = 1'b0;
                    cnt_rst_state_s = 1'b0;
                end
            end
            ST_DONE: begin
                done            = 1'b1;
                cnt_rst_state_s = 1'b1;
            end
            default: begin
                cnt_rst_state_s = 1'b1;
            end
        endcase
    end

    // Run parameters, frozen for the whole run once a start is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_r <= 3'd0;
            hi_r <= 3'd0;
            n_r  <= {SWEEPS_W{1'b0}};
        end else if (start_ok_s) begin
            lo_r <= lo;
            hi_r <= hi;
            n_r  <= n_sweeps;
        end else begin
            lo_r <= lo_r;
            hi_r <= hi_r;
            n_r  <= n_r;
        end
    end

    // Completed-sweep counter: cleared on accepted start, held after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_cnt_r <= {SWEEPS_W{1'b0}};
        end else if (start_ok_s) begin
            sweep_cnt_r <= {SWEEPS_W{1'b0}};
        end else if ((state_r == ST_DOWN) && at_lo_s) begin
            sweep_cnt_r <= turn_cnt_s;
        end else begin
            sweep_cnt_r <= sweep_cnt_r;
        end
    end

    // Rejected-start flag, high for exactly the cycle after the bad request.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= start_bad_s;
        end
    end

endmodule
